// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: turns key press/release edges into per-voice
// configuration writes, stealing the oldest sounding voice when none is free.

module voice_slot #(
    parameter int AGE_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             wr_en,
    input  logic             wr_gate,
    input  logic [6:0]       wr_note,
    input  logic [2:0]       wr_inst,
    output logic             gate,
    output logic [6:0]       note,
    output logic [2:0]       inst,
    output logic [AGE_W-1:0] age
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate <= 1'b0;
            note <= '0;
            inst <= '0;
            age  <= '0;
        end else if (wr_en) begin
            gate <= wr_gate;
            // a release keeps note/inst so the voice's history stays intact
            if (wr_gate) begin
                note <= wr_note;
                inst <= wr_inst;
                age  <= '0;
            end
        end else if (tick && gate && age != '1) begin
            age <= age + AGE_W'(1);
        end
    end
endmodule

module voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int AGE_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [11:0]                   keys,
    input  logic [2:0]                    active_octave,
    input  logic [2:0]                    active_inst,
    input  logic                          next_sample,
    output logic                          cfg_valid,
    input  logic                          cfg_ready,
    output logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
    output logic [6:0]                    cfg_note,
    output logic [2:0]                    cfg_inst,
    output logic                          cfg_gate,
    output logic [NUM_VOICES-1:0]         voices_busy,
    output logic [7:0]                    steal_count
);
    localparam int VW = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {IDLE, SCAN, SEARCH, ISSUE} state_t;

    state_t state, state_next;

    logic [3:0]       idx;
    logic [VW-1:0]    v;
    logic [11:0]      key_prev;
    logic [6:0]       key_note [12];

    logic             ev_press;
    logic [3:0]       ev_idx;
    logic [6:0]       ev_note;
    logic [2:0]       ev_inst;
    logic             is_steal;

    logic             free_found, old_found, match_found;
    logic [VW-1:0]    free_idx, old_idx, match_idx;
    logic [AGE_W-1:0] old_age;

    logic [NUM_VOICES-1:0]            v_gate;
    logic [NUM_VOICES-1:0][6:0]       v_note;
    logic [NUM_VOICES-1:0][2:0]       v_inst;
    logic [NUM_VOICES-1:0][AGE_W-1:0] v_age;

    logic             hs, key_diff, last_v;
    logic [6:0]       press_note;
    logic             cur_gate;
    logic [6:0]       cur_note;
    logic [AGE_W-1:0] cur_age;
    logic             nf_found, no_found, nm_found, no_take;
    logic [VW-1:0]    nf_idx, no_idx, nm_idx;
    logic [AGE_W-1:0] no_age;

    assign cfg_valid   = (state == ISSUE);
    assign hs          = cfg_valid && cfg_ready;
    assign voices_busy = v_gate;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        voice_slot #(.AGE_W(AGE_W)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .tick    (next_sample),
            .wr_en   (hs && cfg_voice == VW'(i)),
            .wr_gate (cfg_gate),
            .wr_note (cfg_note),
            .wr_inst (cfg_inst),
            .gate    (v_gate[i]),
            .note    (v_note[i]),
            .inst    (v_inst[i]),
            .age     (v_age[i])
        );
    end

    // Running search results including the voice visited this cycle, so the
    // decision on the last voice needs no extra cycle.
    always_comb begin
        key_diff   = keys[idx] != key_prev[idx];
        last_v     = (v == VW'(NUM_VOICES - 1));
        press_note = {4'd0, active_octave} * 7'd12 + {3'd0, idx};
        cur_gate   = v_gate[v];
        cur_note   = v_note[v];
        cur_age    = v_age[v];

        nf_found   = free_found || !cur_gate;
        nf_idx     = free_found ? free_idx : v;

        no_take    = cur_gate && (!old_found || cur_age > old_age);
        no_found   = old_found || cur_gate;
        no_idx     = no_take ? v : old_idx;
        no_age     = no_take ? cur_age : old_age;

        nm_found   = match_found || (cur_gate && cur_note == ev_note);
        nm_idx     = match_found ? match_idx : v;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (keys != key_prev) state_next = SCAN;
            SCAN: begin
                if (key_diff)            state_next = SEARCH;
                else if (idx == 4'd11)   state_next = IDLE;
            end
            SEARCH: begin
                // a press always finds a target: either a free or an oldest voice
                if (last_v) state_next = (ev_press || nm_found) ? ISSUE : IDLE;
            end
            ISSUE:  if (cfg_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= '0;
            v           <= '0;
            key_prev    <= '0;
            for (int k = 0; k < 12; k++) key_note[k] <= '0;
            ev_press    <= 1'b0;
            ev_idx      <= '0;
            ev_note     <= '0;
            ev_inst     <= '0;
            is_steal    <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
            match_found <= 1'b0;
            free_idx    <= '0;
            old_idx     <= '0;
            match_idx   <= '0;
            old_age     <= '0;
            cfg_voice   <= '0;
            cfg_note    <= '0;
            cfg_inst    <= '0;
            cfg_gate    <= 1'b0;
            steal_count <= '0;
        end else begin
            case (state)
                IDLE: idx <= '0;
                SCAN: begin
                    idx <= idx + 4'd1;
                    if (key_diff) begin
                        ev_press    <= keys[idx];
                        ev_idx      <= idx;
                        ev_note     <= keys[idx] ? press_note : key_note[idx];
                        ev_inst     <= active_inst;
                        v           <= '0;
                        free_found  <= 1'b0;
                        old_found   <= 1'b0;
                        match_found <= 1'b0;
                    end
                end
                SEARCH: begin
                    v           <= v + VW'(1);
                    free_found  <= nf_found;
                    free_idx    <= nf_idx;
                    old_found   <= no_found;
                    old_idx     <= no_idx;
                    old_age     <= no_age;
                    match_found <= nm_found;
                    match_idx   <= nm_idx;
                    if (last_v) begin
                        if (ev_press) begin
                            cfg_voice <= nf_found ? nf_idx : no_idx;
                            cfg_note  <= ev_note;
                            cfg_inst  <= ev_inst;
                            cfg_gate  <= 1'b1;
                            is_steal  <= !nf_found;
                        end else if (nm_found) begin
                            cfg_voice <= nm_idx;
                            cfg_note  <= v_note[nm_idx];
                            cfg_inst  <= v_inst[nm_idx];
                            cfg_gate  <= 1'b0;
                            is_steal  <= 1'b0;
                        end else begin
                            // the voice was stolen earlier; just retire the key
                            key_prev[ev_idx] <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (cfg_ready) begin
                        key_prev[ev_idx] <= ev_press;
                        if (ev_press) key_note[ev_idx] <= ev_note;
                        if (is_steal && steal_count != 8'hFF)
                            steal_count <= steal_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: scoreboard of expected cfg writes
// plus a vector table and hand-written multi-cycle sequences.

module tb_voice_allocator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] keys = '0;
    logic [2:0]  oct = '0;
    logic [2:0]  inst = '0;
    logic        next_sample = 1'b0;
    logic        cfg_valid;
    logic        cfg_ready = 1'b1;
    logic [2:0]  cfg_voice;
    logic [6:0]  cfg_note;
    logic [2:0]  cfg_inst;
    logic        cfg_gate;
    logic [7:0]  voices_busy;
    logic [7:0]  steal_count;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;

    typedef struct packed {
        logic [2:0] v;
        logic [6:0] note;
        logic [2:0] inst;
        logic       gate;
    } wr_t;

    typedef struct packed {
        logic [11:0] keys;
        logic [2:0]  oct;
        logic [2:0]  inst;
        logic [1:0]  n;
        wr_t         w0;
        wr_t         w1;
        logic [7:0]  busy;
    } vec_t;

    wr_t sb[$];
    vec_t tbl[7];

    voice_allocator #(.NUM_VOICES(8), .AGE_W(16)) dut (
        .clk(clk), .rst(rst), .keys(keys), .active_octave(oct),
        .active_inst(inst), .next_sample(next_sample),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_voice(cfg_voice),
        .cfg_note(cfg_note), .cfg_inst(cfg_inst), .cfg_gate(cfg_gate),
        .voices_busy(voices_busy), .steal_count(steal_count)
    );

    always #5 clk = ~clk;

    function automatic wr_t wr(logic [2:0] v, logic [6:0] nt, logic [2:0] in, logic g);
        return {v, nt, in, g};
    endfunction

    function automatic vec_t mk(logic [11:0] k, logic [2:0] o, logic [2:0] in,
                                logic [1:0] n, wr_t a, wr_t b, logic [7:0] busy);
        vec_t r;
        r.keys = k; r.oct = o; r.inst = in; r.n = n;
        r.w0 = a; r.w1 = b; r.busy = busy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Handshake completes on the next rising edge; sample mid-cycle.
    always @(negedge clk) begin
        if (!rst && cfg_valid && cfg_ready) begin
            wr_t got, exp;
            got = {cfg_voice, cfg_note, cfg_inst, cfg_gate};
            hs_cnt++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write actual=v%0d n%0d i%0d g%0d required=none",
                         got.v, got.note, got.inst, got.gate);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    bad++;
                    $display("FAIL cfg_write actual=v%0d n%0d i%0d g%0d required=v%0d n%0d i%0d g%0d",
                             got.v, got.note, got.inst, got.gate,
                             exp.v, exp.note, exp.inst, exp.gate);
                end
            end
        end
    end

    task automatic wait_sb(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s timeout actual=%0d pending required=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!cfg_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, cfg_valid, 1);
    endtask

    task automatic do_reset();
        keys = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic strobes(input int n);
        repeat (n) begin
            next_sample = 1'b1;
            @(posedge clk); #1;
            next_sample = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int cnt;
        int hs0;

        tbl[0] = mk(12'h000, 3'd5, 3'd0, 2'd1, wr(0, 48, 2, 0), '0,              8'h00);
        tbl[1] = mk(12'h009, 3'd5, 3'd1, 2'd2, wr(0, 60, 1, 1), wr(1, 63, 1, 1), 8'h03);
        tbl[2] = mk(12'h001, 3'd2, 3'd7, 2'd1, wr(1, 63, 1, 0), '0,              8'h01);
        tbl[3] = mk(12'h021, 3'd0, 3'd3, 2'd1, wr(1, 5, 3, 1),  '0,              8'h03);
        tbl[4] = mk(12'h000, 3'd0, 3'd0, 2'd2, wr(0, 60, 1, 0), wr(1, 5, 3, 0),  8'h00);
        tbl[5] = mk(12'h800, 3'd7, 3'd0, 2'd1, wr(0, 95, 0, 1), '0,              8'h01);
        tbl[6] = mk(12'h000, 3'd1, 3'd5, 2'd1, wr(0, 95, 0, 0), '0,              8'h00);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", cfg_valid, 0);
        chk("rst_voice", cfg_voice, 0);
        chk("rst_note",  cfg_note, 0);
        chk("rst_inst",  cfg_inst, 0);
        chk("rst_gate",  cfg_gate, 0);
        chk("rst_busy",  voices_busy, 0);
        chk("rst_steal", steal_count, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // first press latency: 2 + k + NUM_VOICES with k = 0
        oct = 3'd4; inst = 3'd2; keys = 12'h001;
        sb.push_back(wr(0, 48, 2, 1));
        cnt = 0;
        while (!cfg_valid && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency", cnt, 10);
        wait_sb("first_press");
        chk("busy_first", voices_busy, 8'h01);

        for (int i = 0; i < 7; i++) begin
            keys = tbl[i].keys; oct = tbl[i].oct; inst = tbl[i].inst;
            sb.push_back(tbl[i].w0);
            if (tbl[i].n == 2'd2) sb.push_back(tbl[i].w1);
            wait_sb($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_busy", i), voices_busy, tbl[i].busy);
        end
        chk("steal_none", steal_count, 0);

        // fill all voices with ageing gaps, then steal the oldest
        do_reset();
        oct = 3'd4; inst = 3'd0;
        for (int i = 0; i < 8; i++) begin
            keys = keys | (12'h001 << i);
            sb.push_back(wr(3'(i), 7'(48 + i), 0, 1));
            wait_sb($sformatf("fill%0d", i));
            if (i < 7) strobes(10);
        end
        chk("busy_full", voices_busy, 8'hFF);
        keys = keys | 12'h100;
        sb.push_back(wr(0, 56, 0, 1));
        wait_sb("steal");
        chk("steal_count", steal_count, 1);
        chk("busy_steal", voices_busy, 8'hFF);

        hs0 = hs_cnt;
        keys = 12'h1FE;
        repeat (40) @(posedge clk);
        #1;
        chk("stolen_release_nowrite", hs_cnt, hs0);
        chk("busy_after_stolen_rel", voices_busy, 8'hFF);

        keys = 12'h0FE;
        sb.push_back(wr(0, 56, 0, 0));
        wait_sb("rel_key8");
        chk("busy_rel8", voices_busy, 8'hFE);

        // back-pressure: outputs hold, one update after ready
        cfg_ready = 1'b0;
        oct = 3'd4; inst = 3'd6;
        keys = keys | 12'h200;
        sb.push_back(wr(0, 57, 6, 1));
        wait_valid("hold_valid");
        hs0 = hs_cnt;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d_out", c),
                {cfg_valid, cfg_voice, cfg_note, cfg_inst, cfg_gate},
                {1'b1, 3'd0, 7'd57, 3'd6, 1'b1});
            chk($sformatf("hold%0d_busy", c), voices_busy, 8'hFE);
        end
        chk("hold_pending", sb.size(), 1);
        cfg_ready = 1'b1;
        wait_sb("hold_release");
        chk("hold_one_hs", hs_cnt, hs0 + 1);
        chk("busy_hold", voices_busy, 8'hFF);
        chk("steal_hold", steal_count, 1);

        // reset while a write is pending
        cfg_ready = 1'b0;
        keys = keys | 12'h400;
        wait_valid("rst_pending_valid");
        hs0 = hs_cnt;
        #2 rst = 1'b1;
        #1;
        chk("async_valid", cfg_valid, 0);
        chk("async_busy", voices_busy, 0);
        chk("async_steal", steal_count, 0);
        keys = '0;
        cfg_ready = 1'b1;
        @(negedge clk) rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_valid", cfg_valid, 0);
        chk("post_rst_nohs", hs_cnt, hs0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
